// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types, defaults and width helpers for the Sobel sequencer
// Purpose: state encodings (4-bit), default image geometry and datapath latency,
//          and the counter-width helper used by every file of the block.
// Ports:   none (package).
// Config:  SOBEL_BORDA_EN (border-pixel transmit of 0x00) is consumed by the
//          interface and the top, not here.
package sobel_pkg;

  typedef enum logic [3:0] {
    OCIOSO       = 4'd0,
    ESPERA_RX    = 4'd1,
    ESCREVE      = 4'd2,
    CALCULA      = 4'd3,
    AGUARDA_CALC = 4'd4,
    TRANSMITE    = 4'd5,
    ESPERA_TX    = 4'd6,
    AVANCA       = 4'd7,
    FIM          = 4'd8
  } estado_t;

  localparam int LARGURA_PADRAO  = 64;
  localparam int ALTURA_PADRAO   = 64;
  localparam int LAT_CALC_PADRAO = 2;

  // Bits needed to hold 0..n-1; never narrower than one bit.
  function automatic int largura_contador(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sobel_escalonador_if.sv
// rtl/sobel_escalonador_if.sv - handshake bundle between the sequencer, UART and Sobel datapath
// Purpose: groups the UART rx/tx handshakes and the line-buffer / Sobel control strobes.
// Signals: rx_pronto, tx_pronto (to sequencer); rx_enable, tx_enable, tx_partida,
//          lb_escreve, lb_endereco, lb_desloca, sobel_calcula, sobel_fim_imagem,
//          zera_saida (only with SOBEL_BORDA_EN) (from sequencer).
// Modports: master = sequencer side, slave = UART/datapath side.
// Config:  SOBEL_BORDA_EN adds zera_saida.
interface sobel_escalonador_if #(
  parameter int LARGURA = sobel_pkg::LARGURA_PADRAO
);
  import sobel_pkg::*;

  localparam int LW = largura_contador(LARGURA);

  logic          rx_pronto;
  logic          tx_pronto;
  logic          rx_enable;
  logic          tx_enable;
  logic          tx_partida;
  logic          lb_escreve;
  logic [LW-1:0] lb_endereco;
  logic          lb_desloca;
  logic          sobel_calcula;
  logic          sobel_fim_imagem;
`ifdef SOBEL_BORDA_EN
  logic          zera_saida;

  modport master (
    input  rx_pronto, tx_pronto,
    output rx_enable, tx_enable, tx_partida, lb_escreve, lb_endereco,
           lb_desloca, sobel_calcula, sobel_fim_imagem, zera_saida
  );

  modport slave (
    output rx_pronto, tx_pronto,
    input  rx_enable, tx_enable, tx_partida, lb_escreve, lb_endereco,
           lb_desloca, sobel_calcula, sobel_fim_imagem, zera_saida
  );
`else
  modport master (
    input  rx_pronto, tx_pronto,
    output rx_enable, tx_enable, tx_partida, lb_escreve, lb_endereco,
           lb_desloca, sobel_calcula, sobel_fim_imagem
  );

  modport slave (
    output rx_pronto, tx_pronto,
    input  rx_enable, tx_enable, tx_partida, lb_escreve, lb_endereco,
           lb_desloca, sobel_calcula, sobel_fim_imagem
  );
`endif

endinterface

// File: rtl/sobel_contador_raster.sv
// rtl/sobel_contador_raster.sv - raster row/column counter for the Sobel sequencer
// Purpose: tracks the current pixel position in raster order.
// Ports:   clock, reset (sync, active-low), limpa (clear to 0,0), avanca (step one pixel),
//          linha, coluna (position), ultimo_pixel (position is the last pixel of the image).
module sobel_contador_raster
  import sobel_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO,
  parameter int ALTURA  = ALTURA_PADRAO
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  limpa,
  input  logic                                  avanca,
  output logic [largura_contador(ALTURA)-1:0]   linha,
  output logic [largura_contador(LARGURA)-1:0]  coluna,
  output logic                                  ultimo_pixel
);

  localparam int LWL = largura_contador(ALTURA);
  localparam int LWC = largura_contador(LARGURA);
  localparam logic [LWL-1:0] LIN_MAX = LWL'(ALTURA - 1);
  localparam logic [LWC-1:0] COL_MAX = LWC'(LARGURA - 1);

  always_ff @(posedge clock) begin
    if (!reset || limpa) begin
      linha  <= '0;
      coluna <= '0;
    end else if (avanca) begin
      if (coluna == COL_MAX) begin
        coluna <= '0;
        linha  <= linha + 1'b1;
      end else begin
        coluna <= coluna + 1'b1;
      end
    end
  end

  assign ultimo_pixel = (linha == LIN_MAX) && (coluna == COL_MAX);

endmodule

// File: rtl/sobel_escalonador.sv
// rtl/sobel_escalonador.sv - sequencing controller for the Sobel pixel pipeline
// Purpose: takes raster pixel bytes from the UART receiver, drives line-buffer writes
//          and window shifts, fires the Sobel compute once a full 3x3 window exists,
//          and hands each result to the UART transmitter.
// Ports:   clock, reset (sync, active-low), iniciar (start/restart in OCIOSO/FIM),
//          bus (sobel_escalonador_if.master: UART handshakes + datapath strobes),
//          pronto (image done), erro_overrun (sticky dropped-byte flag),
//          db_estado / db_linha / db_coluna (debug view of state and position).
// Config:  SOBEL_BORDA_EN - border pixels also transmit, with zera_saida forcing 0x00.
module sobel_escalonador
  import sobel_pkg::*;
#(
  parameter int LARGURA  = LARGURA_PADRAO,
  parameter int ALTURA   = ALTURA_PADRAO,
  parameter int LAT_CALC = LAT_CALC_PADRAO
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  iniciar,
  sobel_escalonador_if.master                   bus,
  output logic                                  pronto,
  output logic                                  erro_overrun,
  output logic [3:0]                            db_estado,
  output logic [largura_contador(ALTURA)-1:0]   db_linha,
  output logic [largura_contador(LARGURA)-1:0]  db_coluna
);

  localparam int LWL   = largura_contador(ALTURA);
  localparam int LWC   = largura_contador(LARGURA);
  localparam int LAT_W = largura_contador(LAT_CALC);
  localparam logic [LAT_W-1:0] LAT_CARGA = LAT_W'(LAT_CALC - 1);

  estado_t          estado;
  logic [LAT_W-1:0] lat_cnt;
  logic [LWL-1:0]   linha;
  logic [LWC-1:0]   coluna;
  logic             ultimo_pixel;
  logic             janela_cheia;
  logic             limpa;
  logic             avanca;

  // A full 3x3 window exists once two rows and two columns are already buffered.
  assign janela_cheia = (linha >= LWL'(2)) && (coluna >= LWC'(2));

  assign limpa  = ((estado == OCIOSO) || (estado == FIM)) && iniciar;
  // On the last pixel the counters hold so FIM still reports the final position.
  assign avanca = (estado == AVANCA) && !ultimo_pixel;

  sobel_contador_raster #(
    .LARGURA (LARGURA),
    .ALTURA  (ALTURA)
  ) u_contador (
    .clock        (clock),
    .reset        (reset),
    .limpa        (limpa),
    .avanca       (avanca),
    .linha        (linha),
    .coluna       (coluna),
    .ultimo_pixel (ultimo_pixel)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado       <= OCIOSO;
      lat_cnt      <= '0;
      erro_overrun <= 1'b0;
    end else begin
      // Any byte arriving while not waiting for one is lost; flag it until reset.
      if (bus.rx_pronto && (estado != ESPERA_RX)) begin
        erro_overrun <= 1'b1;
      end
      case (estado)
        OCIOSO, FIM: begin
          if (iniciar) estado <= ESPERA_RX;
        end
        ESPERA_RX: begin
          if (bus.rx_pronto) estado <= ESCREVE;
        end
        ESCREVE: begin
          if (janela_cheia) begin
            estado <= CALCULA;
          end else begin
`ifdef SOBEL_BORDA_EN
            estado <= TRANSMITE;
`else
            estado <= AVANCA;
`endif
          end
        end
        CALCULA: begin
          lat_cnt <= LAT_CARGA;
          estado  <= AGUARDA_CALC;
        end
        AGUARDA_CALC: begin
          if (lat_cnt == '0) estado <= TRANSMITE;
          else               lat_cnt <= lat_cnt - 1'b1;
        end
        TRANSMITE: begin
          // tx_pronto in this cycle belongs to no transfer of ours and is ignored.
          estado <= ESPERA_TX;
        end
        ESPERA_TX: begin
          if (bus.tx_pronto) estado <= AVANCA;
        end
        AVANCA: begin
          estado <= ultimo_pixel ? FIM : ESPERA_RX;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  // Outputs are pure decodes of registered state/position; no input reaches them directly.
  assign bus.rx_enable        = (estado == ESPERA_RX);
  assign bus.tx_enable        = (estado == TRANSMITE) || (estado == ESPERA_TX);
  assign bus.tx_partida       = (estado == TRANSMITE);
  assign bus.lb_escreve       = (estado == ESCREVE);
  assign bus.lb_desloca       = (estado == ESCREVE);
  assign bus.lb_endereco      = coluna;
  assign bus.sobel_calcula    = (estado == CALCULA);
  assign bus.sobel_fim_imagem = (estado == FIM);
`ifdef SOBEL_BORDA_EN
  assign bus.zera_saida       = bus.tx_enable && !janela_cheia;
`endif

  assign pronto    = (estado == FIM);
  assign db_estado = estado;
  assign db_linha  = linha;
  assign db_coluna = coluna;

endmodule

// File: tb/tb_sobel_escalonador.sv
// tb/tb_sobel_escalonador.sv - directed self-checking bench for sobel_escalonador (4x4, LAT_CALC=3)
module tb_sobel_escalonador;

`ifdef SOBEL_BORDA_EN
  localparam int EXP_TX   = 16;
  localparam int EXP_ZERO = 12;
`else
  localparam int EXP_TX   = 4;
  localparam int EXP_ZERO = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       pronto;
  logic       erro_overrun;
  logic [3:0] db_estado;
  logic [1:0] db_linha;
  logic [1:0] db_coluna;
  logic       zflag;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int calc_cyc = 0;
  int n_calc = 0;
  int n_tx = 0;
  int n_zero = 0;
  int n_wr = 0;
  int n_lat_bad = 0;
  int tx_cd = 0;
  logic [3:0] pos_q[$];

  always #5 clk = ~clk;

  sobel_escalonador_if #(.LARGURA(4)) bus ();

  sobel_escalonador #(
    .LARGURA  (4),
    .ALTURA   (4),
    .LAT_CALC (3)
  ) dut (
    .clock        (clk),
    .reset        (reset),
    .iniciar      (iniciar),
    .bus          (bus),
    .pronto       (pronto),
    .erro_overrun (erro_overrun),
    .db_estado    (db_estado),
    .db_linha     (db_linha),
    .db_coluna    (db_coluna)
  );

`ifdef SOBEL_BORDA_EN
  assign zflag = bus.zera_saida;
`else
  assign zflag = 1'b0;
`endif

  // Monitor and transmitter model: tx_pronto returns 5 cycles after each tx_partida.
  always @(negedge clk) begin
    cyc++;
    bus.tx_pronto = 1'b0;
    if (tx_cd > 0) begin
      tx_cd--;
      if (tx_cd == 0) bus.tx_pronto = 1'b1;
    end
    if (bus.sobel_calcula) begin
      n_calc++;
      calc_cyc = cyc;
    end
    if (bus.lb_escreve) n_wr++;
    if (bus.tx_partida) begin
      n_tx++;
      tx_cd = 5;
      if (zflag) begin
        n_zero++;
      end else begin
        pos_q.push_back({db_linha, db_coluna});
        if (cyc - calc_cyc != 4) n_lat_bad++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [3:0] s, input string tag);
    int n;
    n = 0;
    while (db_estado !== s && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk(tag, {28'd0, db_estado}, {28'd0, s});
  endtask

  task automatic send_pixel(input int k);
    wait_state(4'd1, "timeout_espera_rx");
    bus.rx_pronto = 1'b1;
    @(negedge clk);
    bus.rx_pronto = 1'b0;
    chk("lb_escreve", {31'd0, bus.lb_escreve}, 32'd1);
    chk("lb_endereco", {30'd0, bus.lb_endereco}, 32'(k % 4));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_estado"}, {28'd0, db_estado}, 32'd0);
    chk({tag, "_strobes"}, {24'd0, bus.rx_enable, bus.tx_enable, bus.tx_partida, bus.lb_escreve,
        bus.lb_desloca, bus.sobel_calcula, bus.sobel_fim_imagem, pronto}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, erro_overrun}, 32'd0);
    chk({tag, "_linha"}, {30'd0, db_linha}, 32'd0);
    chk({tag, "_coluna"}, {30'd0, db_coluna}, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    iniciar = 1'b0;
    bus.rx_pronto = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset_inicial");
    reset = 1'b1;
    @(negedge clk);
    chk("ocioso_sem_iniciar", {28'd0, db_estado}, 32'd0);

    // Image 1: mid-image iniciar and an overrun during ESPERA_TX.
    iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    chk("partida_estado", {28'd0, db_estado}, 32'd1);
    chk("partida_rx_enable", {31'd0, bus.rx_enable}, 32'd1);
    for (int k = 0; k < 16; k++) begin
      if (k == 1) begin
        wait_state(4'd1, "timeout_meio");
        iniciar = 1'b1;
        @(negedge clk);
        iniciar = 1'b0;
        chk("iniciar_meio_estado", {28'd0, db_estado}, 32'd1);
        chk("iniciar_meio_coluna", {30'd0, db_coluna}, 32'd1);
      end
      send_pixel(k);
      if (k == 10) begin
        wait_state(4'd6, "timeout_espera_tx");
        bus.rx_pronto = 1'b1;
        @(negedge clk);
        bus.rx_pronto = 1'b0;
        chk("overrun_set", {31'd0, erro_overrun}, 32'd1);
        chk("overrun_estado", {28'd0, db_estado}, 32'd6);
      end
    end
    wait_state(4'd8, "timeout_fim1");
    chk("fim1_estado", {28'd0, db_estado}, 32'd8);
    chk("fim1_fim_imagem", {31'd0, bus.sobel_fim_imagem}, 32'd1);
    chk("fim1_pronto", {31'd0, pronto}, 32'd1);
    chk("fim1_linha", {30'd0, db_linha}, 32'd3);
    chk("fim1_coluna", {30'd0, db_coluna}, 32'd3);
    chk("fim1_overrun", {31'd0, erro_overrun}, 32'd1);
    chk("img1_calc", 32'(n_calc), 32'd4);
    chk("img1_tx", 32'(n_tx), 32'(EXP_TX));
    chk("img1_zero", 32'(n_zero), 32'(EXP_ZERO));
    chk("img1_writes", 32'(n_wr), 32'd16);
    chk("img1_lat", 32'(n_lat_bad), 32'd0);
    chk("img1_npos", 32'(pos_q.size()), 32'd4);
    chk("img1_pos0", {28'd0, pos_q[0]}, 32'hA);
    chk("img1_pos1", {28'd0, pos_q[1]}, 32'hB);
    chk("img1_pos2", {28'd0, pos_q[2]}, 32'hE);
    chk("img1_pos3", {28'd0, pos_q[3]}, 32'hF);
    repeat (3) @(negedge clk);
    chk("fim1_permanece", {28'd0, db_estado}, 32'd8);

    // Restart from FIM: counters clear, overrun stays.
    iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    chk("reinicio_estado", {28'd0, db_estado}, 32'd1);
    chk("reinicio_linha", {30'd0, db_linha}, 32'd0);
    chk("reinicio_coluna", {30'd0, db_coluna}, 32'd0);
    chk("reinicio_overrun", {31'd0, erro_overrun}, 32'd1);
    for (int k = 0; k < 16; k++) send_pixel(k);
    wait_state(4'd8, "timeout_fim2");
    chk("fim2_estado", {28'd0, db_estado}, 32'd8);
    chk("img2_calc", 32'(n_calc), 32'd8);
    chk("img2_tx", 32'(n_tx), 32'(2 * EXP_TX));
    chk("img2_zero", 32'(n_zero), 32'(2 * EXP_ZERO));
    chk("img2_writes", 32'(n_wr), 32'd32);
    chk("img2_lat", 32'(n_lat_bad), 32'd0);
    chk("img2_npos", 32'(pos_q.size()), 32'd8);
    chk("img2_pos4", {28'd0, pos_q[4]}, 32'hA);
    chk("img2_pos7", {28'd0, pos_q[7]}, 32'hF);

    // Image 3: reset asserted mid-ESPERA_TX.
    iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    for (int k = 0; k < 11; k++) send_pixel(k);
    wait_state(4'd6, "timeout_espera_tx3");
    chk("img3_espera_tx", {28'd0, db_estado}, 32'd6);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset_meio");
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("pos_reset_estado", {28'd0, db_estado}, 32'd0);
    chk("pos_reset_overrun", {31'd0, erro_overrun}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
